dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Registered two-requester arbiter in front of the single D-cache port inside the memory system. Replaces the combinational use_dcache steering mux.
- Requester 0 is the MMU page-table walker (reads only, priority). Requester 1 is the pipeline load/store path (reads and writes).
- Serialises one outstanding cache transaction at a time, routes each response only to its owner, and gates virtual-mode per owner.
- Adds a starvation guard for the pipeline and a watchdog for hung transactions.

Parameters:
- MAX_MMU_BURST, default 4: consecutive MMU grants allowed while the pipeline is waiting before the pipeline is forced ahead.
- TIMEOUT_CYCLES, default 1024: cycles in a busy state without a cache response before the sticky error is raised.
- CNT_W, default $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- virtual_en  in  1  decoded SATP virtual mode.
- mmu_req  in  1  MMU read request; held until mmu_resp_valid.
- mmu_addr  in  64  physical PTE address.
- mmu_resp_valid  out  1  one-cycle response pulse to the MMU.
- mmu_rdata  out  64  PTE data, valid with mmu_resp_valid.
- pipe_req  in  1  pipeline request; held until pipe_rvalid or pipe_write_done.
- pipe_addr  in  64  pipeline address.
- pipe_wrn  in  1  1 = write, 0 = read.
- pipe_wdata  in  64  write data.
- pipe_wlen  in  2  log2 of byte count.
- pipe_rdata  out  64  read data.
- pipe_rvalid  out  1  read response pulse.
- pipe_write_done  out  1  write completion pulse.
- dc_enable  out  1  D-cache enable.
- dc_addr  out  64  muxed address.
- dc_wrn  out  1  muxed write flag.
- dc_wdata  out  64  muxed write data.
- dc_wlen  out  2  muxed write length.
- dc_virtual_mode  out  1  virtual-mode flag to the D-cache.
- dc_rdata  in  64  D-cache read data.
- dc_valid  in  1  D-cache read-valid pulse.
- dc_write_done  in  1  D-cache write-done pulse.
- grant_mmu  out  1  MMU owns the port (replaces use_dcache).
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- States are IDLE, BUSY_MMU, BUSY_PIPE. A single cycle of IDLE always separates two transactions, so dc_enable drops for at least one cycle between them.
- Reset: synchronous, takes priority over everything including an in-flight transaction.
  - State goes to IDLE, starve_cnt=0, wdog_cnt=0, timeout_err=0.
  - All outputs are 0 during the reset cycle and the cycle after.
  - A cache response arriving in those cycles is dropped.
- IDLE grant decision:
  - Only mmu_req: go to BUSY_MMU.
  - Only pipe_req: go to BUSY_PIPE.
  - Both: go to BUSY_MMU unless starve_cnt==MAX_MMU_BURST, in which case go to BUSY_PIPE.
  - Neither: stay in IDLE.
- Grant latency is 1 cycle. A request seen in IDLE in cycle N gives dc_enable=1 from cycle N+1.
- Mux outputs are driven from the owner's live inputs while busy.
  - BUSY_MMU: dc_wrn=0, dc_wdata=0, dc_wlen=0, dc_virtual_mode=0.
  - BUSY_PIPE: the pipe_* fields pass through, and dc_virtual_mode=virtual_en.
  - IDLE: dc_enable=0 and all dc_* outputs are 0.
- Responses are routed combinationally in the same cycle as dc_valid or dc_write_done.
  - BUSY_MMU: mmu_resp_valid=dc_valid and mmu_rdata=dc_rdata. A dc_write_done here is ignored and flagged by an assertion.
  - BUSY_PIPE: pipe_rvalid=dc_valid, pipe_write_done=dc_write_done, pipe_rdata=dc_rdata.
  - The non-owner's response outputs and rdata are held at 0.
  - After a response the state returns to IDLE on the next edge.
- Responses seen in IDLE are discarded, and a simulation assertion fires.
- starve_cnt (saturating at MAX_MMU_BURST):
  - +1 on each MMU grant made while pipe_req=1.
  - Cleared on a pipeline grant.
  - Cleared in any IDLE cycle with pipe_req=0.
- Requester protocol:
  - A requester must hold its req and fields stable until its response.
  - If req deasserts mid-transaction, the transaction still completes and the response still pulses.
- Watchdog:
  - wdog_cnt counts cycles spent in a busy state and clears on entry to IDLE.
  - Reaching TIMEOUT_CYCLES sets timeout_err (cleared only by reset).
  - The counter saturates, and the state machine keeps waiting (no abort).
- grant_mmu = (state==BUSY_MMU). It is registered and has no glitches.

Decomposition:
- mem_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_MMU, ARB_BUSY_PIPE} arb_state_t;
  - localparam for the owner encodings;
  - the PRIV_* constants, which move here from the current shared location.
- Optional sub-module arb_watchdog: a saturating counter plus sticky flag, parameterised by TIMEOUT_CYCLES. Everything else stays flat.

Test Plan:
- Single MMU read: mmu_req=1 with addr 0x8000_1000 in cycle 0.
  - Expect dc_enable=1 and dc_addr=0x8000_1000 in cycle 1.
  - dc_valid with rdata 0xDEAD_BEEF in cycle 4 gives mmu_resp_valid=1, mmu_rdata=0xDEAD_BEEF, pipe_rvalid=0.
  - Expect IDLE in cycle 5.
- Pipeline write in virtual mode: pipe_req=1, wrn=1, wdata=0x1234, wlen=3, virtual_en=1.
  - Expect dc_virtual_mode=1 and dc_wlen=3.
  - dc_write_done gives pipe_write_done=1 for exactly one cycle.
- Simultaneous requests: both asserted, each response 3 cycles after enable.
  - Expect MMU served first, one IDLE cycle, then pipeline.
  - Expect dc_virtual_mode=0 throughout the MMU transaction.
- Starvation: MMU re-requests continuously while pipe_req=1, MAX_MMU_BURST=4.
  - Expect exactly 4 MMU grants, then a pipeline grant.
  - Expect starve_cnt back at 0 afterwards.
- Reset mid-transaction: reset asserted in BUSY_PIPE, with dc_valid arriving the same cycle.
  - Expect no pipe_rvalid, dc_enable=0 next cycle, state IDLE.
- Watchdog: TIMEOUT_CYCLES=8 and no response.
  - Expect timeout_err=1 at cycle 8 of BUSY, still set after a late response.
  - Expect it cleared only by reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-system D-cache port arbitration.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_MMU,
    ARB_BUSY_PIPE
  } arb_state_t;

  // Requester encodings used wherever an owner is carried as a single bit.
  localparam logic OWNER_MMU  = 1'b0;
  localparam logic OWNER_PIPE = 1'b1;

  // Privilege levels shared by the MMU and memory-system blocks.
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: saturating counter plus sticky timeout flag.
// Latency: flag rises in the busy cycle where the count reaches TIMEOUT_CYCLES.
// Backpressure: none; observes only, never aborts the transaction.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic busy_next,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count busy cycles (cycle k of a transaction holds k), saturate, clear on idle.
  always_comb begin
    cnt_d = '0;
    if (busy_next) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Counter register and sticky error; only reset clears the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_d == LIMIT) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Registered MMU/pipeline arbiter for the single D-cache port, one transaction at a time.
// Latency: grant 1 cycle after request; responses routed combinationally to the owner.
// Backpressure: losing requester simply holds req; MMU priority bounded by MAX_MMU_BURST.
module dcache_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_MMU_BURST  = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        virtual_en,
  input  logic        mmu_req,
  input  logic [63:0] mmu_addr,
  output logic        mmu_resp_valid,
  output logic [63:0] mmu_rdata,
  input  logic        pipe_req,
  input  logic [63:0] pipe_addr,
  input  logic        pipe_wrn,
  input  logic [63:0] pipe_wdata,
  input  logic [1:0]  pipe_wlen,
  output logic [63:0] pipe_rdata,
  output logic        pipe_rvalid,
  output logic        pipe_write_done,
  output logic        dc_enable,
  output logic [63:0] dc_addr,
  output logic        dc_wrn,
  output logic [63:0] dc_wdata,
  output logic [1:0]  dc_wlen,
  output logic        dc_virtual_mode,
  input  logic [63:0] dc_rdata,
  input  logic        dc_valid,
  input  logic        dc_write_done,
  output logic        grant_mmu,
  output logic        timeout_err
);

  localparam int                ST_W       = $clog2(MAX_MMU_BURST + 1);
  localparam logic [ST_W-1:0]   STARVE_MAX = ST_W'(MAX_MMU_BURST);

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic [ST_W-1:0] starve_cnt;
  logic            wdog_err;

  // Next-state: grant from IDLE (MMU first unless the pipeline is starved), release on response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (mmu_req && !(pipe_req && starve_cnt == STARVE_MAX)) begin
          state_d = ARB_BUSY_MMU;
        end else if (pipe_req) begin
          state_d = ARB_BUSY_PIPE;
        end
      end
      ARB_BUSY_MMU: begin
        if (dc_valid) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_PIPE: begin
        if (dc_valid || dc_write_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; reset wins over any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter: MMU grants won while the pipeline waits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (!pipe_req || state_d == ARB_BUSY_PIPE) begin
        starve_cnt <= '0;
      end else if (state_d == ARB_BUSY_MMU && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + ST_W'(1);
      end
    end
  end

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wdog (
    .clk         (clk),
    .reset       (reset),
    .busy_next   (state_d != ARB_IDLE),
    .timeout_err (wdog_err)
  );

  // Port mux and response routing; everything is forced quiet while reset is asserted.
  always_comb begin
    dc_enable       = 1'b0;
    dc_addr         = '0;
    dc_wrn          = 1'b0;
    dc_wdata        = '0;
    dc_wlen         = '0;
    dc_virtual_mode = 1'b0;
    mmu_resp_valid  = 1'b0;
    mmu_rdata       = '0;
    pipe_rvalid     = 1'b0;
    pipe_write_done = 1'b0;
    pipe_rdata      = '0;
    grant_mmu       = 1'b0;
    timeout_err     = 1'b0;
    if (!reset) begin
      timeout_err = wdog_err;
      unique case (state_q)
        ARB_BUSY_MMU: begin
          grant_mmu      = 1'b1;
          dc_enable      = 1'b1;
          dc_addr        = mmu_addr;
          mmu_resp_valid = dc_valid;
          mmu_rdata      = dc_rdata;
        end
        ARB_BUSY_PIPE: begin
          dc_enable       = 1'b1;
          dc_addr         = pipe_addr;
          dc_wrn          = pipe_wrn;
          dc_wdata        = pipe_wdata;
          dc_wlen         = pipe_wlen;
          dc_virtual_mode = virtual_en;
          pipe_rvalid     = dc_valid;
          pipe_write_done = dc_write_done;
          pipe_rdata      = dc_rdata;
        end
        default: ;
      endcase
    end
  end

  // The cache must never answer an idle port, and the walker never issues writes.
  a_no_idle_resp: assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_IDLE) |-> !(dc_valid || dc_write_done));
  a_no_mmu_write_done: assert property (@(posedge clk) disable iff (reset)
    (state_q == ARB_BUSY_MMU) |-> !dc_write_done);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        virtual_en = 1'b0;
  logic        mmu_req = 1'b0;
  logic [63:0] mmu_addr = '0;
  logic        mmu_resp_valid;
  logic [63:0] mmu_rdata;
  logic        pipe_req = 1'b0;
  logic [63:0] pipe_addr = '0;
  logic        pipe_wrn = 1'b0;
  logic [63:0] pipe_wdata = '0;
  logic [1:0]  pipe_wlen = '0;
  logic [63:0] pipe_rdata;
  logic        pipe_rvalid;
  logic        pipe_write_done;
  logic        dc_enable;
  logic [63:0] dc_addr;
  logic        dc_wrn;
  logic [63:0] dc_wdata;
  logic [1:0]  dc_wlen;
  logic        dc_virtual_mode;
  logic [63:0] dc_rdata = '0;
  logic        dc_valid = 1'b0;
  logic        dc_write_done = 1'b0;
  logic        grant_mmu;
  logic        timeout_err;

  dcache_port_arbiter #(
    .MAX_MMU_BURST  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk), .reset (reset), .virtual_en (virtual_en),
    .mmu_req (mmu_req), .mmu_addr (mmu_addr),
    .mmu_resp_valid (mmu_resp_valid), .mmu_rdata (mmu_rdata),
    .pipe_req (pipe_req), .pipe_addr (pipe_addr), .pipe_wrn (pipe_wrn),
    .pipe_wdata (pipe_wdata), .pipe_wlen (pipe_wlen),
    .pipe_rdata (pipe_rdata), .pipe_rvalid (pipe_rvalid), .pipe_write_done (pipe_write_done),
    .dc_enable (dc_enable), .dc_addr (dc_addr), .dc_wrn (dc_wrn), .dc_wdata (dc_wdata),
    .dc_wlen (dc_wlen), .dc_virtual_mode (dc_virtual_mode),
    .dc_rdata (dc_rdata), .dc_valid (dc_valid), .dc_write_done (dc_write_done),
    .grant_mmu (grant_mmu), .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [63:0] data;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] mmu_q[$];
  exp_t        pipe_q[$];
  logic        grant_log[$];
  int          starve_log[$];
  logic        prev_en = 1'b0;
  logic        cache_auto = 1'b1;
  int          cache_cnt = 0;
  exp_t        e6;
  logic        exp_g[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int          exp_s[6] = '{1, 2, 3, 4, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cache_data(input logic [63:0] a);
    if (a == 64'h8000_1000) return 64'hDEAD_BEEF;
    return a ^ 64'h5A5A_0000_0000_1111;
  endfunction

  // Cache model: answers in the 4th enabled cycle (3 cycles after enable).
  always @(negedge clk) begin
    if (!cache_auto) begin
      cache_cnt = 0;
    end else begin
      dc_valid      = 1'b0;
      dc_write_done = 1'b0;
      dc_rdata      = '0;
      if (dc_enable) begin
        cache_cnt++;
        if (cache_cnt == 4) begin
          cache_cnt = 0;
          if (dc_wrn) dc_write_done = 1'b1;
          else begin
            dc_valid = 1'b1;
            dc_rdata = cache_data(dc_addr);
          end
        end
      end else begin
        cache_cnt = 0;
      end
    end
  end

  // Scoreboard: pop the owner's expectation on every response pulse.
  always @(negedge clk) begin
    #2;
    if (mmu_resp_valid) begin
      check("mmu_q_nonempty", 64'(mmu_q.size() != 0), 1);
      if (mmu_q.size() != 0) check("mmu_rdata", mmu_rdata, mmu_q.pop_front());
      check("mmu_resp_pipe_quiet", {pipe_rvalid, pipe_write_done}, 0);
    end
    if (pipe_rvalid || pipe_write_done) begin
      check("pipe_q_nonempty", 64'(pipe_q.size() != 0), 1);
      if (pipe_q.size() != 0) begin
        exp_t e;
        e = pipe_q.pop_front();
        check("pipe_write_done_kind", pipe_write_done, e.wr);
        check("pipe_rvalid_kind", pipe_rvalid, !e.wr);
        if (!e.wr) check("pipe_rdata", pipe_rdata, e.data);
      end
      check("pipe_resp_mmu_quiet", mmu_resp_valid, 0);
    end
  end

  // Grant recorder: owner and starvation count at the first cycle of each grant.
  always @(negedge clk) begin
    #1;
    if (dc_enable && !prev_en) begin
      grant_log.push_back(grant_mmu);
      starve_log.push_back(int'(dut.starve_cnt));
    end
    prev_en = dc_enable;
  end

  task automatic mmu_read(input logic [63:0] a);
    int n = 0;
    mmu_addr = a;
    mmu_req  = 1'b1;
    mmu_q.push_back(cache_data(a));
    do begin
      @(negedge clk); #1; n++;
    end while (!mmu_resp_valid && n < 100);
    check("mmu_resp_seen", mmu_resp_valid, 1);
    mmu_req = 1'b0;
  endtask

  task automatic pipe_op(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input logic [1:0] wl);
    int   n = 0;
    exp_t e;
    pipe_addr  = a;
    pipe_wrn   = wr;
    pipe_wdata = wd;
    pipe_wlen  = wl;
    pipe_req   = 1'b1;
    e.wr   = wr;
    e.data = wr ? 64'h0 : cache_data(a);
    pipe_q.push_back(e);
    do begin
      @(negedge clk); #1; n++;
    end while (!(pipe_rvalid || pipe_write_done) && n < 100);
    check("pipe_resp_seen", pipe_rvalid | pipe_write_done, 1);
    pipe_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset state
    @(negedge clk); #1;
    check("rst_dc_enable", dc_enable, 0);
    check("rst_grant_mmu", grant_mmu, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_resp", {mmu_resp_valid, pipe_rvalid, pipe_write_done}, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    check("rst_state_idle", 64'(dut.state_q), 64'(ARB_IDLE));
    check("rst_starve", 64'(dut.starve_cnt), 0);

    // Single MMU read, cycle-accurate
    @(negedge clk);
    virtual_en = 1'b1;
    mmu_addr   = 64'h8000_1000;
    mmu_req    = 1'b1;
    mmu_q.push_back(64'hDEAD_BEEF);
    @(negedge clk); #1;
    check("t1_enable_c1", dc_enable, 1);
    check("t1_addr_c1", dc_addr, 64'h8000_1000);
    check("t1_grant_c1", grant_mmu, 1);
    check("t1_vm_c1", dc_virtual_mode, 0);
    check("t1_wrn_c1", dc_wrn, 0);
    @(negedge clk);
    @(negedge clk); #1;
    check("t1_no_early_resp_c3", mmu_resp_valid, 0);
    @(negedge clk); #1;
    check("t1_resp_c4", mmu_resp_valid, 1);
    check("t1_rdata_c4", mmu_rdata, 64'hDEAD_BEEF);
    check("t1_pipe_quiet_c4", pipe_rvalid, 0);
    mmu_req = 1'b0;
    @(negedge clk); #1;
    check("t1_idle_c5", 64'(dut.state_q), 64'(ARB_IDLE));
    check("t1_enable_c5", dc_enable, 0);

    // Pipeline write in virtual mode
    @(negedge clk);
    fork
      pipe_op(1'b1, 64'h4000_0100, 64'h1234, 2'd3);
      begin
        @(negedge clk); #1;
        check("t2_enable", dc_enable, 1);
        check("t2_vm", dc_virtual_mode, 1);
        check("t2_wlen", dc_wlen, 3);
        check("t2_wrn", dc_wrn, 1);
        check("t2_wdata", dc_wdata, 64'h1234);
        check("t2_addr", dc_addr, 64'h4000_0100);
        check("t2_grant", grant_mmu, 0);
      end
    join
    @(negedge clk); #1;
    check("t2_write_done_once", pipe_write_done, 0);
    check("t2_enable_off", dc_enable, 0);

    // Simultaneous requests: MMU, one idle cycle, then pipeline
    @(negedge clk);
    fork
      mmu_read(64'h8000_3000);
      pipe_op(1'b0, 64'h4000_0200, 64'h0, 2'd0);
      begin
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk); #1;
          check($sformatf("t3_enable_c%0d", i), dc_enable, 64'((i <= 4) || (i >= 6 && i <= 9)));
          check($sformatf("t3_grant_c%0d", i), grant_mmu, 64'(i <= 4));
          if (dc_enable) check($sformatf("t3_vm_c%0d", i), dc_virtual_mode, 64'(!grant_mmu));
        end
      end
    join

    // Starvation guard: four MMU grants, then the pipeline
    @(negedge clk);
    grant_log.delete();
    starve_log.delete();
    fork
      for (int k = 0; k < 5; k++) mmu_read(64'h8000_2000 + 64'(k * 8));
      pipe_op(1'b0, 64'h4000_0300, 64'h0, 2'd0);
    join
    @(negedge clk); #1;
    check("t4_grant_count", 64'(grant_log.size()), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check($sformatf("t4_owner_%0d", i), grant_log[i], exp_g[i]);
      check($sformatf("t4_starve_%0d", i), 64'(starve_log[i]), 64'(exp_s[i]));
    end
    check("t4_starve_final", 64'(dut.starve_cnt), 0);

    // Reset mid-transaction with a response in the reset cycle
    @(negedge clk);
    cache_auto = 1'b0;
    pipe_addr  = 64'h4000_0400;
    pipe_wrn   = 1'b0;
    pipe_req   = 1'b1;
    @(negedge clk); #1;
    check("t5_busy_pipe", 64'(dut.state_q), 64'(ARB_BUSY_PIPE));
    @(negedge clk);
    reset    = 1'b1;
    dc_valid = 1'b1;
    dc_rdata = 64'hBAD0_BAD0;
    #1;
    check("t5_rvalid_in_reset", pipe_rvalid, 0);
    check("t5_rdata_in_reset", pipe_rdata, 0);
    check("t5_enable_in_reset", dc_enable, 0);
    @(negedge clk);
    reset    = 1'b0;
    dc_valid = 1'b0;
    dc_rdata = '0;
    pipe_req = 1'b0;
    #1;
    check("t5_enable_after", dc_enable, 0);
    check("t5_state_after", 64'(dut.state_q), 64'(ARB_IDLE));
    check("t5_rvalid_after", pipe_rvalid, 0);

    // Watchdog: no response, error at busy cycle 8, sticky until reset
    @(negedge clk);
    pipe_addr = 64'h4000_0500;
    pipe_wrn  = 1'b0;
    pipe_req  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk); #1;
      check($sformatf("wd_err_c%0d", i), timeout_err, 64'(i >= 8));
    end
    check("wd_cnt_saturated", 64'(dut.u_wdog.cnt_q), 8);
    check("wd_still_waiting", dc_enable, 1);
    @(negedge clk);
    e6.wr   = 1'b0;
    e6.data = 64'h5555;
    pipe_q.push_back(e6);
    dc_valid = 1'b1;
    dc_rdata = 64'h5555;
    #1;
    check("wd_late_resp", pipe_rvalid, 1);
    pipe_req = 1'b0;
    @(negedge clk);
    dc_valid = 1'b0;
    dc_rdata = '0;
    #1;
    check("wd_idle_after_late", dc_enable, 0);
    check("wd_sticky", timeout_err, 1);
    repeat (3) @(negedge clk);
    #1;
    check("wd_sticky_later", timeout_err, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("wd_reset_cycle", timeout_err, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wd_cleared", timeout_err, 0);
    @(negedge clk); #1;
    check("wd_cleared_later", timeout_err, 0);

    check("mmu_q_drained", 64'(mmu_q.size()), 0);
    check("pipe_q_drained", 64'(pipe_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
